// File: rtl/phase_timer.sv
// Up-counter with a run-time limit, parallel load, wrap/one-shot modes and registered Wrap/Done status.
// Optional count prescaler enabled by defining PHASE_TIMER_PRESCALE_EN.
module phase_timer #(
  parameter int WIDTH    = 7,
  parameter int PRESCALE = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             Count,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic [WIDTH-1:0] Limit,
  input  logic             Mode,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap,
  output logic             Done
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_done;
  logic             w_tick;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_done_nxt;

`ifdef PHASE_TIMER_PRESCALE_EN
  localparam int               PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  // Prescaler only advances on enabled cycles; a tick is its terminal count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)           r_pre <= '0;
    else if (Clear || Load) r_pre <= '0;
    else if (Count)         r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
  end

  assign w_tick = Count && (r_pre == PRE_MAX);
`else
  assign w_tick = Count;
`endif

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    w_done_nxt = r_done;
    if (Clear) begin
      w_q_nxt    = '0;
      w_done_nxt = 1'b0;
    end else if (Load) begin
      w_q_nxt    = (LoadValue > Limit) ? Limit : LoadValue;
      w_done_nxt = 1'b0;
    end else if (w_tick) begin
      // Q above Limit only happens after Limit is lowered; treat it as terminal.
      if (r_q < Limit) begin
        w_q_nxt = r_q + 1'b1;
      end else if (!Mode) begin
        w_q_nxt    = '0;
        w_wrap_nxt = 1'b1;
      end else begin
        w_q_nxt    = Limit;
        w_done_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign Q    = r_q;
  assign Wrap = r_wrap;
  assign Done = r_done;

endmodule

// File: tb/tb_phase_timer.sv
// Directed, table-driven bench for phase_timer (WIDTH=7, PRESCALE=4).
// Prescaler sequences run only when PHASE_TIMER_PRESCALE_EN is defined.
module tb_phase_timer;

  localparam int W = 7;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Clear, Count, Load, Mode;
  logic [W-1:0] LoadValue, Limit;
  logic [W-1:0] Q;
  logic         Wrap, Done;

  int n_checks = 0;
  int n_fail   = 0;

  phase_timer #(.WIDTH(W), .PRESCALE(4)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Clear     (Clear),
    .Count     (Count),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Limit     (Limit),
    .Mode      (Mode),
    .Q         (Q),
    .Wrap      (Wrap),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         clr, ld;
    logic [W-1:0] lv, lim;
    logic         mode, cnt;
    logic [W-1:0] q;
    logic         wrap, done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic clr, input logic ld, input int lv, input int lim,
                      input logic mode, input logic cnt);
    @(negedge Clk);
    Clear = clr; Load = ld; LoadValue = W'(lv); Limit = W'(lim); Mode = mode; Count = cnt;
    @(posedge Clk);
    #1;
  endtask

  function automatic vec_t mk(input logic clr, ld, input int lv, lim, input logic mode, cnt,
                              input int q, input logic wrap, done);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = W'(lv); v.lim = W'(lim); v.mode = mode; v.cnt = cnt;
    v.q = W'(q); v.wrap = wrap; v.done = done;
    return v;
  endfunction

  initial begin
    Reset_n = 1'b0; Clear = 0; Count = 0; Load = 0; Mode = 0; LoadValue = '0; Limit = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_q", Q, 0);
    chk("reset_wrap", Wrap, 0);
    chk("reset_done", Done, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

`ifndef PHASE_TIMER_PRESCALE_EN
    //            clr ld lv  lim mode cnt  q   wrap done
    vecs.push_back(mk(0, 0,   0,   5, 1, 1,   1, 0, 0));
    vecs.push_back(mk(0, 0,   0,   5, 1, 1,   2, 0, 0));
    vecs.push_back(mk(0, 0,   0,   5, 1, 1,   3, 0, 0));
    vecs.push_back(mk(0, 0,   0,   5, 1, 1,   4, 0, 0));
    vecs.push_back(mk(0, 0,   0,   5, 1, 1,   5, 0, 0));
    vecs.push_back(mk(0, 0,   0,   5, 1, 1,   5, 0, 1));
    vecs.push_back(mk(0, 0,   0,   5, 1, 1,   5, 0, 1));
    vecs.push_back(mk(0, 0,   0,   5, 1, 0,   5, 0, 1));
    vecs.push_back(mk(0, 1,   2,   5, 1, 1,   2, 0, 0));
    vecs.push_back(mk(0, 0,   0,   5, 1, 1,   3, 0, 0));
    vecs.push_back(mk(1, 1,   9,   5, 1, 1,   0, 0, 0));
    vecs.push_back(mk(0, 0,   0,   3, 0, 1,   1, 0, 0));
    vecs.push_back(mk(0, 0,   0,   3, 0, 1,   2, 0, 0));
    vecs.push_back(mk(0, 1, 100,  20, 0, 0,  20, 0, 0));
    vecs.push_back(mk(0, 0,   0,  20, 0, 1,   0, 1, 0));
    vecs.push_back(mk(0, 0,   0,  20, 0, 1,   1, 0, 0));
    vecs.push_back(mk(0, 0,   0,  20, 0, 0,   1, 0, 0));
    vecs.push_back(mk(0, 0,   0,   0, 0, 1,   0, 1, 0));
    vecs.push_back(mk(0, 0,   0,   0, 0, 1,   0, 1, 0));
    vecs.push_back(mk(0, 0,   0,   0, 0, 0,   0, 0, 0));
    vecs.push_back(mk(0, 0,   0,   0, 1, 1,   0, 0, 1));
    vecs.push_back(mk(0, 0,   0,   0, 1, 1,   0, 0, 1));
    vecs.push_back(mk(1, 0,   0,   0, 1, 0,   0, 0, 0));
    vecs.push_back(mk(0, 1,  30,  60, 0, 0,  30, 0, 0));
    vecs.push_back(mk(0, 0,   0,  60, 0, 1,  31, 0, 0));
    vecs.push_back(mk(0, 0,   0,  10, 0, 1,   0, 1, 0));
    vecs.push_back(mk(0, 1, 127, 127, 1, 0, 127, 0, 0));
    vecs.push_back(mk(0, 0,   0, 127, 1, 1, 127, 0, 1));
    vecs.push_back(mk(0, 0,   0, 127, 0, 1,   0, 1, 1));
    vecs.push_back(mk(1, 0,   0, 127, 0, 0,   0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].lim, vecs[i].mode, vecs[i].cnt);
      chk($sformatf("vec%0d_q", i), Q, vecs[i].q);
      chk($sformatf("vec%0d_wrap", i), Wrap, vecs[i].wrap);
      chk($sformatf("vec%0d_done", i), Done, vecs[i].done);
    end

    // Free-running wrap mode, Limit=124: period of 125 ticks.
    begin
      int eq = 0;
      int last_wrap = -1;
      for (int i = 0; i < 250; i++) begin
        step(0, 0, 0, 124, 0, 1);
        eq = (eq == 124) ? 0 : eq + 1;
        chk($sformatf("run%0d_q", i), Q, eq);
        chk($sformatf("run%0d_wrap", i), Wrap, (eq == 0) ? 1 : 0);
        if (Wrap) begin
          if (last_wrap >= 0) chk("wrap_period", i - last_wrap, 125);
          last_wrap = i;
        end
      end
      chk("run_last_wrap", last_wrap, 249);
    end
`else
    // Prescaler: 8 counting cycles produce two increments.
    step(1, 0, 0, 100, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 100, 0, 1);
      chk($sformatf("pre%0d_q", i), Q, i / 4);
    end
    // A 3-cycle Count gap pushes the next increment out by exactly 3 cycles.
    step(1, 0, 0, 100, 0, 0);
    begin
      logic [6:0] cnt_pat;
      int         eq = 0;
      int         run = 0;
      cnt_pat = 7'b1100011;
      for (int i = 0; i < 7; i++) begin
        step(0, 0, 0, 100, 0, cnt_pat[6-i]);
        if (cnt_pat[6-i]) run++;
        if (run == 4 && cnt_pat[6-i]) eq = 1;
        chk($sformatf("gap%0d_q", i), Q, eq);
      end
      chk("gap_final_q", Q, 1);
    end
    // Load zeroes the prescaler: four more counts needed after it.
    step(0, 0, 0, 100, 0, 1);
    step(0, 1, 10, 100, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 100, 0, 1);
      chk($sformatf("preld%0d_q", i), Q, (i == 4) ? 11 : 10);
    end
`endif

    // Asynchronous reset mid-count with Done set.
    step(0, 1, 57, 57, 1, 0);
    step(0, 0, 0, 57, 1, 1);
    chk("pre_rst_q", Q, 57);
    chk("pre_rst_done", Done, 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("async_rst_q", Q, 0);
    chk("async_rst_wrap", Wrap, 0);
    chk("async_rst_done", Done, 0);
    #1 Reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 200000);
    $fatal(1);
  end

endmodule
